// File: rtl/mux_pkg.sv
// Shared types and helpers for the 4-to-1 round-robin stream mux.
// Channel count, select width, output-stage states and one-hot decode.
package mux_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef logic [SEL_W-1:0] ch_sel_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_t;

  function automatic ch_sel_t onehot_to_sel(input logic [NUM_CH-1:0] oh);
    ch_sel_t s;
    s = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (oh[i]) s = s | ch_sel_t'(i);
    end
    return s;
  endfunction

endpackage

// File: rtl/rr_mux_4x1_if.sv
// Stream bundle between four producers, the mux and one consumer.
// master drives valids/data/out_ready; slave is the mux side.
interface rr_mux_4x1_if #(
  parameter int WIDTH = 8
);
  import mux_pkg::*;

  logic [NUM_CH-1:0]       in_valid;
  logic [NUM_CH*WIDTH-1:0] in_data;
  logic [NUM_CH-1:0]       in_ready;
  logic                    out_valid;
  logic [WIDTH-1:0]        out_data;
  ch_sel_t                 out_sel;
  logic                    out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );

endinterface

// File: rtl/rr_arbiter_4.sv
// Combinational 4-way round-robin arbiter; search starts at last+1 and wraps.
// Zero latency; grant is one-hot or zero and never looks at data.
module rr_arbiter_4
  import mux_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  ch_sel_t           last,
  output logic [NUM_CH-1:0] grant
);

  ch_sel_t idx;
  logic    found;

  // k = NUM_CH truncates to 0, so the last candidate is the previous winner itself.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = last + ch_sel_t'(k);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_mux_4x1.sv
// Registered 4-to-1 round-robin stream mux tagging each beat with its channel.
// Latency 1 cycle; a stalled output freezes the register and drops all in_ready.
module rr_mux_4x1
  import mux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  rr_mux_4x1_if.slave  bus
);

  out_state_t        state_q, state_d;
  logic [WIDTH-1:0]  data_q, data_d;
  ch_sel_t           sel_q, sel_d;
  ch_sel_t           last_q, last_d;

  logic              load_en;
  logic [NUM_CH-1:0] grant;
  logic [NUM_CH-1:0] ready;
  logic              xfer;
  ch_sel_t           win_sel;
  logic [WIDTH-1:0]  win_data;

  assign load_en = (state_q == ST_EMPTY) || bus.out_ready;

  rr_arbiter_4 u_arb (
    .req   (bus.in_valid),
    .last  (last_q),
    .grant (grant)
  );

  // rst_n gating keeps producers from seeing a handshake while the register is held in reset.
  assign ready   = grant & {NUM_CH{load_en & rst_n}};
  assign xfer    = |(bus.in_valid & ready);
  assign win_sel = onehot_to_sel(grant);

  always_comb begin
    win_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant[i]) win_data = bus.in_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    last_d  = last_q;
    case (state_q)
      ST_EMPTY: begin
        if (xfer) state_d = ST_FULL;
      end
      ST_FULL: begin
        if (bus.out_ready && !xfer) state_d = ST_EMPTY;
      end
      default: state_d = ST_EMPTY;
    endcase
    if (xfer) begin
      data_d = win_data;
      sel_d  = win_sel;
      last_d = win_sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      sel_q   <= '0;
      last_q  <= ch_sel_t'(NUM_CH - 1);
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = (state_q == ST_FULL);
  assign bus.out_data  = data_q;
  assign bus.out_sel   = sel_q;

endmodule

// File: doc/rr_mux_4x1.md
# rr_mux_4x1

Registered 4-to-1 stream multiplexer with round-robin arbitration: merges four valid/ready input channels onto one output channel and tags each beat with a 2-bit channel index. It is the collecting end paired with the 1x4 demultiplexer. A downstream 1x4 demux fed by `out_sel`/`out_data` restores the original channel split.

## Interface
- `WIDTH`, 8, data width of every channel.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  asynchronous active-low reset.
- `in_valid`  input  4  per-channel valid; bit i belongs to channel i.
- `in_data`  input  4*WIDTH  channel i data on bits [i*WIDTH +: WIDTH].
- `in_ready`  output  4  per-channel ready; at most one bit high per cycle.
- `out_valid`  output  1  output beat present.
- `out_data`  output  WIDTH  registered data of the granted channel.
- `out_sel`  output  2  index of the channel that produced `out_data`.
- `out_ready`  input  1  downstream accepts the beat.

## Operation
- Output stage is one holding register: `out_valid`, `out_data`, `out_sel`.
- `load_en = !out_valid || out_ready`. The register may take a new beat only when `load_en` is high.
- Arbiter:
  - Combinational round-robin over `in_valid`, searching from `last_grant+1` mod 4 upward with wrap-around.
  - `grant` is one-hot or zero.
- `in_ready = grant & {4{load_en}}`. A transfer on channel i occurs when `in_valid[i] && in_ready[i]`.
- On a transfer:
  - `out_data <= in_data[i]`, `out_sel <= i`, `out_valid <= 1`, `last_grant <= i`.
- With no transfer and `out_ready` high: `out_valid <= 0`. `out_data` and `out_sel` hold their last values.
- With `out_valid` high and `out_ready` low: every output is frozen, all `in_ready` bits are 0, and `last_grant` holds.
- Two-state view:
  - EMPTY (`out_valid=0`) → FULL on any transfer.
  - FULL → EMPTY when `out_ready` is high and there is no transfer.
  - FULL → FULL when `out_ready` is high and a transfer occurs (back-to-back), or while `out_ready` is low (stall).
- Fairness: a channel that keeps valid high is granted at least once in every 4 transfers.
- Upstream rule: `in_data[i]` must stay stable while `in_valid[i]` is high and not yet accepted. The block does not check this.
- `in_valid` may drop without a transfer; the arbiter re-evaluates every cycle.

## Timing
- Latency: 1 cycle from input transfer to `out_valid`/`out_data` visible.
- Throughput: 1 beat per cycle while `out_ready` stays high and any input is valid.
- `in_ready` depends combinationally on `in_valid`, `out_valid`, `out_ready` and `last_grant`. It does not depend on `in_data`.
- Reset (async assert, release synchronous to `clk` by the system):
  - `out_valid=0`, `out_data=0`, `out_sel=0`, `last_grant=3` (so channel 0 wins first).
  - `in_ready=0` only while `rst_n` is low.
- Reset mid-stall drops the held beat; that data is discarded by design.
- Simultaneous events:
  - A pop and a push in the same cycle keep `out_valid` at 1 with the new beat.
  - With all four valid and continuous `out_ready`, `out_sel` sequences 0,1,2,3,0,...

## Structure
- Package `mux_pkg`:
  - `NUM_CH=4`, `SEL_W=2`.
  - Typedef `ch_sel_t` (logic [SEL_W-1:0]).
  - One-hot-to-index function `onehot_to_sel`.
- Sub-module `rr_arbiter_4`:
  - Ports `req[3:0]`, `last[1:0]` → `grant[3:0]`.
  - Purely combinational; `last_grant` register lives in the parent.
- The parent holds the output register, `load_en` and the ready gating.
- Target size: about 150–200 lines total.

## Test plan
- Reset: with `rst_n=0`, drive all `in_valid=4'hF` → `out_valid=0`, `in_ready=0`, `out_data=0`. After release, the first grant goes to ch0.
- Single channel: ch2 valid with data 8'hA5, `out_ready=1` → next cycle `out_valid=1`, `out_data=A5`, `out_sel=2`; one cycle later `out_valid=0`.
- Round robin: `in_valid=4'hF`, data i→8'h10+i, `out_ready=1` for 8 cycles → `out_sel` is 0,1,2,3,0,1,2,3 and `out_data` is 10,11,12,13,10,...
- Backpressure: ch1 loads 8'h3C, then `out_ready=0` for 5 cycles with `in_valid=4'hF` → `out_data=3C` and `out_sel=1` held, `in_ready=0`. On release, `out_ready=1` → next grant is ch2.
- Skip idle: `last_grant=0`, `in_valid=4'b1001` → ch3 granted before ch0. Then with `in_valid=4'b0001`, ch0 is granted with wrap-around.
- Async reset mid-stream: assert `rst_n=0` between clock edges while `out_valid=1` → `out_valid` drops immediately. After release, ch0 has priority again.
